// File: rtl/uart_rx.sv
// UART receive deserializer: 2-flop input sync, falling-edge start detect,
// mid-bit sampling on the oversample tick, LSB-first shift, stop-bit check.
module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_in,
  input  logic                 nrst_in,
  input  logic                 baud_tick_in,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid_out,
  output logic                 frame_err_out,
  output logic                 busy_out
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_prev;

  logic [1:0]           state;
  logic [1:0]           state_nxt;
  logic [TW-1:0]        tick_cnt;
  logic [TW-1:0]        tick_nxt;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 valid_nxt;
  logic                 ferr_nxt;
  logic                 busy_nxt;

  // Synchronize the asynchronous line and keep one extra stage for edge detect
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      state         <= IDLE;
      tick_cnt      <= '0;
      bit_cnt       <= '0;
      shift_q       <= '0;
      data_out      <= '0;
      valid_out     <= 1'b0;
      frame_err_out <= 1'b0;
      busy_out      <= 1'b0;
    end else begin
      state         <= state_nxt;
      tick_cnt      <= tick_nxt;
      bit_cnt       <= bit_nxt;
      shift_q       <= shift_nxt;
      data_out      <= data_nxt;
      valid_out     <= valid_nxt;
      frame_err_out <= ferr_nxt;
      busy_out      <= busy_nxt;
    end
  end

  // Next-state and output decode; without a tick everything holds
  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_q;
    data_nxt  = data_out;
    valid_nxt = 1'b0;
    ferr_nxt  = 1'b0;

    case (state)
      IDLE: begin
        // A line stuck low shows no edge, so it cannot re-arm the receiver
        if (rx_prev && !rx_s) begin
          state_nxt = START;
          tick_nxt  = '0;
        end
      end

      START: begin
        if (baud_tick_in) begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt = '0;
            if (!rx_s) begin
              state_nxt = DATA;
              bit_nxt   = '0;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      DATA: begin
        if (baud_tick_in) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            shift_nxt = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
              state_nxt = STOP;
            end else begin
              bit_nxt = bit_cnt + BW'(1);
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      STOP: begin
        // Leaving mid stop bit lets a back-to-back start edge be caught
        if (baud_tick_in) begin
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            if (rx_s) begin
              data_nxt  = shift_q;
              valid_nxt = 1'b1;
            end else begin
              ferr_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + TW'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx with a frame-level scoreboard.
module tb_uart_rx;

  localparam int unsigned TICK_DIV = 10;
  localparam int unsigned OS       = 16;
  localparam int unsigned BIT_CLKS = TICK_DIV * OS;
  localparam int          ERR_EV   = -1;

  logic       clk_in;
  logic       nrst_in;
  logic       baud_tick_in;
  logic       rx_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       frame_err_out;
  logic       busy_out;

  int total;
  int bad;
  int cyc;
  int t_start;
  int t_fall;
  int overlap;
  int longpulse;
  logic stall;
  logic prev_v;
  logic prev_fe;
  logic prev_busy;
  int tcnt;
  int exp_q[$];
  int got_q[$];
  int last_good;

  uart_rx #(.DATA_BITS(8), .OVERSAMPLE(OS)) dut (
    .clk_in        (clk_in),
    .nrst_in       (nrst_in),
    .baud_tick_in  (baud_tick_in),
    .rx_in         (rx_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .frame_err_out (frame_err_out),
    .busy_out      (busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc++;

  // Oversample tick source; freezes its phase while stalled
  initial begin
    tcnt = 0;
    baud_tick_in = 1'b0;
    forever begin
      @(negedge clk_in);
      if (stall) begin
        baud_tick_in = 1'b0;
      end else begin
        baud_tick_in = (tcnt == TICK_DIV - 1);
        tcnt = (tcnt == TICK_DIV - 1) ? 0 : tcnt + 1;
      end
    end
  end

  // Output monitor: collect events and watch pulse shape
  initial begin
    prev_v = 0; prev_fe = 0; prev_busy = 0; overlap = 0; longpulse = 0; t_fall = 0;
    forever begin
      @(negedge clk_in);
      if (valid_out) got_q.push_back(int'(data_out));
      if (frame_err_out) got_q.push_back(ERR_EV);
      if (valid_out && frame_err_out) overlap++;
      if ((valid_out && prev_v) || (frame_err_out && prev_fe)) longpulse++;
      if (prev_busy && !busy_out) t_fall = cyc;
      prev_v = valid_out;
      prev_fe = frame_err_out;
      prev_busy = busy_out;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic send_bit(input logic b, input int stall_clks);
    rx_in = b;
    if (stall_clks > 0) begin
      stall = 1'b1;
      wait_clks(stall_clks / 2);
      chk("stall_busy", busy_out, 1);
      chk("stall_data", data_out, last_good);
      chk("stall_noev", got_q.size(), 0);
      wait_clks(stall_clks - stall_clks / 2);
      stall = 1'b0;
    end
    wait_clks(BIT_CLKS);
  endtask

  // Bit 0 is the start bit, 1..8 data LSB first, 9 stop; abort>=0 stops after that many data bits
  task automatic send_frame(input logic [7:0] b, input logic stop, input int stall_bit,
                            input int abort);
    logic bv;
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      if (abort >= 0 && i > abort) return;
      bv = (i == 0) ? 1'b0 : (i == 9) ? stop : b[i-1];
      send_bit(bv, (i == stall_bit) ? 200 : 0);
    end
    if (stop) begin
      exp_q.push_back(int'(b));
      last_good = int'(b);
    end else begin
      exp_q.push_back(ERR_EV);
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    wait_clks(4);
    chk($sformatf("%s_count", tag), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_ev%0d", tag, i), got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int diff;
    logic [7:0] rb;
    logic rs;
    total = 0; bad = 0; cyc = 0; last_good = 0;
    stall = 1'b0;
    rx_in = 1'b1;
    nrst_in = 1'b0;
    wait_clks(5);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_ferr", frame_err_out, 0);
    chk("rst_busy", busy_out, 0);
    nrst_in = 1'b1;
    wait_clks(BIT_CLKS);

    // Single good frame and busy duration
    send_frame(8'hA5, 1'b1, -1, -1);
    wait_clks(4);
    diff = t_fall - t_start;
    chk("busy_fall_win", (diff >= 1505 && diff <= 1535), 1);
    chk("t1_data", data_out, 8'hA5);
    check_events("t1");

    // Short start glitch is rejected
    rx_in = 1'b0;
    wait_clks(20);
    chk("glitch_busy_hi", busy_out, 1);
    wait_clks(4 * TICK_DIV - 20);
    rx_in = 1'b1;
    wait_clks(60);
    chk("glitch_busy_lo", busy_out, 0);
    wait_clks(BIT_CLKS);
    check_events("t2");

    // Bad stop bit keeps the previous byte
    send_frame(8'h3C, 1'b0, -1, -1);
    rx_in = 1'b1;
    wait_clks(BIT_CLKS);
    chk("t3_data_kept", data_out, last_good);
    check_events("t3");

    // Back-to-back frames
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    send_frame(8'h55, 1'b1, -1, -1);
    check_events("t4");

    // Reset mid-frame drops the partial byte
    send_frame(8'h81, 1'b1, -1, 3);
    nrst_in = 1'b0;
    rx_in = 1'b1;
    wait_clks(5);
    chk("t5_rst_busy", busy_out, 0);
    chk("t5_rst_data", data_out, 0);
    last_good = 0;
    nrst_in = 1'b1;
    wait_clks(BIT_CLKS);
    got_q.delete();
    send_frame(8'h42, 1'b1, -1, -1);
    check_events("t5");

    // Tick stall in the middle of a frame
    send_frame(8'h96, 1'b1, 4, -1);
    check_events("t6");

    // Random frames with random gaps and occasional framing errors
    for (int k = 0; k < 8; k++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) != 0);
      send_frame(rb, rs, -1, -1);
      rx_in = 1'b1;
      if (!rs) wait_clks(BIT_CLKS);
      wait_clks(int'($urandom_range(0, 2)) * BIT_CLKS);
    end
    check_events("rnd");
    chk("rnd_data", data_out, last_good);

    chk("no_overlap", overlap, 0);
    chk("pulse_1clk", longpulse, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
